// File: rtl/mpadd_seq_pkg.sv
// Shared definitions for the multi-precision add sequencer: state encoding
// and the byte-counter width helper.
package mpadd_seq_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CARRY = 1'b1
    } state_e;

    // Never returns zero so a one-byte limit still gets a real counter.
    function automatic int cnt_width(input int max_bytes);
        return (max_bytes > 1) ? $clog2(max_bytes) : 1;
    endfunction

endpackage

// File: rtl/mpadd_seq_add8_c.sv
// Shared 8-bit datapath adder with carry in and carry out; purely combinational.
module add8_c (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign sum  = full[7:0];
    assign cout = full[8];

endmodule

// File: rtl/mpadd_seq.sv
// Byte-serial multi-precision adder sequencer: LSB-first operand stream in,
// sum stream out through a single registered output slot.
module mpadd_seq
    import mpadd_seq_pkg::*;
#(
    parameter int MAX_BYTES  = 8,
    parameter int EMIT_CARRY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_sum,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       carry_out,
    output logic       len_err,
    output logic       busy
);

    localparam int CW = cnt_width(MAX_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BYTES - 1);

    // Handshake rule for both streams: a beat transfers on the rising edge
    // where valid and ready are both high; valid never waits on ready.

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          carry_q, carry_d;
    logic [7:0]    out_sum_q, out_sum_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          carry_out_q, carry_out_d;
    logic          len_err_q, len_err_d;

    logic [7:0]    add_sum;
    logic          add_cout;
    logic          slot_free;
    logic          accept;
    logic          at_limit;
    logic          final_byte;
    logic          truncate;

    add8_c u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = (state_q == ST_RUN) && slot_free;
    assign accept     = in_valid && in_ready;
    assign at_limit   = (count_q == LAST_IDX);
    assign final_byte = in_last || at_limit;
    assign truncate   = at_limit && !in_last;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        carry_out_d = carry_out_q;
        len_err_d   = len_err_q;

        // Default drain; a load below overrides it in the same cycle.
        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    out_sum_d   = add_sum;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    carry_d     = add_cout;
                    count_d     = count_q + CW'(1);
                    if (count_q == '0) begin
                        len_err_d = 1'b0;
                    end
                    if (truncate) begin
                        len_err_d = 1'b1;
                    end
                    if (final_byte) begin
                        if (EMIT_CARRY != 0) begin
                            state_d = ST_CARRY;
                        end else begin
                            out_last_d  = 1'b1;
                            carry_out_d = add_cout;
                            carry_d     = 1'b0;
                            count_d     = '0;
                        end
                    end
                end
            end
            ST_CARRY: begin
                if (slot_free) begin
                    out_sum_d   = {7'd0, carry_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    carry_out_d = carry_q;
                    carry_d     = 1'b0;
                    count_d     = '0;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            carry_q     <= 1'b0;
            out_sum_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            carry_out_q <= carry_out_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign carry_out = carry_out_q;
    assign len_err   = len_err_q;
    assign busy      = (count_q != '0) || (state_q == ST_CARRY) || out_valid_q;

endmodule

// File: tb/tb_mpadd_seq.sv
// Bench for mpadd_seq: three instances (EMIT_CARRY=0, EMIT_CARRY=1, MAX_BYTES=4)
// driven with directed vectors and checked by per-instance output monitors.
`timescale 1ns/1ps
module tb_mpadd_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_a      [3];
    logic [7:0] in_b      [3];
    logic       in_valid  [3];
    logic       in_last   [3];
    logic       in_ready  [3];
    logic [7:0] out_sum   [3];
    logic       out_valid [3];
    logic       out_last  [3];
    logic       out_ready [3];
    logic       carry_out [3];
    logic       len_err   [3];
    logic       busy      [3];

    logic [8:0] exp_q [3][$];
    int n_cmp;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT instances ----------------
    for (genvar k = 0; k < 3; k++) begin : g_dut
        mpadd_seq #(
            .MAX_BYTES  ((k == 2) ? 4 : 8),
            .EMIT_CARRY ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_a      (in_a[k]),
            .in_b      (in_b[k]),
            .in_valid  (in_valid[k]),
            .in_last   (in_last[k]),
            .in_ready  (in_ready[k]),
            .out_sum   (out_sum[k]),
            .out_valid (out_valid[k]),
            .out_last  (out_last[k]),
            .out_ready (out_ready[k]),
            .carry_out (carry_out[k]),
            .len_err   (len_err[k]),
            .busy      (busy[k])
        );

        // Output monitor: pops one expectation per transferred sum byte.
        always begin
            logic [8:0] e;
            @(negedge clk);
            #2;
            if (rst_n && out_valid[k] && out_ready[k]) begin
                n_cmp++;
                if (exp_q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL out_byte_%0d: unexpected byte last=%0b sum=%02h, required none", k, out_last[k], out_sum[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    if ({out_last[k], out_sum[k]} !== e) begin
                        n_fail++;
                        $display("FAIL out_byte_%0d: got last=%0b sum=%02h, required last=%0b sum=%02h",
                                 k, out_last[k], out_sum[k], e[8], e[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic last, input logic [7:0] es, input logic el);
        logic got;
        exp_q[k].push_back({el, es});
        in_a[k]     = a;
        in_b[k]     = b;
        in_last[k]  = last;
        in_valid[k] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            got = in_ready[k];
            @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_timeout_%0d: got no in_ready, required accept within 40 cycles", k);
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_a[k] = 8'd0; in_b[k] = 8'd0; in_valid[k] = 1'b0;
            in_last[k] = 1'b0; out_ready[k] = 1'b1;
        end
        idle(2);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_outputs_%0d", k),
                {11'd0, out_valid[k], out_last[k], carry_out[k], len_err[k], busy[k]}, 16'd0);
            chk($sformatf("reset_sum_%0d", k), {8'd0, out_sum[k]}, 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // EMIT_CARRY=0: single byte, two-byte chain, carry-out set and cleared
        send(0, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1);
        idle(2); #1 chk("ec0_single_carry_out", {15'd0, carry_out[0]}, 16'd0);
        send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
        send(0, 8'h01, 8'h00, 1'b1, 8'h02, 1'b1);
        idle(2); #1 chk("ec0_two_byte_carry_out", {15'd0, carry_out[0]}, 16'd0);
        send(0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0);
        send(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        idle(2); #1 chk("ec0_overflow_carry_out", {15'd0, carry_out[0]}, 16'd1);
        send(0, 8'h01, 8'h01, 1'b1, 8'h02, 1'b1);
        idle(2); #1 chk("ec0_carry_out_cleared", {15'd0, carry_out[0]}, 16'd0);
        idle(1);

        // Backpressure mid-transaction
        send(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        out_ready[0] = 1'b0;
        fork
            send(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    #3;
                    chk("bp_in_ready", {15'd0, in_ready[0]}, 16'd0);
                    chk("bp_hold", {7'd0, out_valid[0], out_sum[0]}, {7'd0, 1'b1, 8'h30});
                    @(negedge clk);
                end
                out_ready[0] = 1'b1;
            end
        join
        send(0, 8'h05, 8'h06, 1'b1, 8'h0B, 1'b1);
        idle(2); #1 chk("bp_carry_out", {15'd0, carry_out[0]}, 16'd0);
        idle(1);

        // EMIT_CARRY=1: carry byte follows, in_ready low during CARRY
        send(1, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b0);
        exp_q[1].push_back({1'b1, 8'h01});
        #1 chk("ec1_carry_state_in_ready", {15'd0, in_ready[1]}, 16'd0);
        idle(2); #1 chk("ec1_carry_out_set", {15'd0, carry_out[1]}, 16'd1);
        idle(1);
        send(1, 8'h34, 8'h01, 1'b0, 8'h35, 1'b0);
        send(1, 8'h12, 8'h00, 1'b1, 8'h12, 1'b0);
        exp_q[1].push_back({1'b1, 8'h00});
        idle(3); #1 chk("ec1_carry_out_clear", {15'd0, carry_out[1]}, 16'd0);
        idle(1);

        // MAX_BYTES=4 truncation, carry dropped at the forced boundary
        send(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
        send(2, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0);
        send(2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 chk("trunc_len_err_before", {15'd0, len_err[2]}, 16'd0);
        send(2, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        #1 chk("trunc_len_err_set", {15'd0, len_err[2]}, 16'd1);
        chk("trunc_carry_out", {15'd0, carry_out[2]}, 16'd1);
        send(2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 chk("trunc_len_err_cleared", {15'd0, len_err[2]}, 16'd0);
        idle(3);

        // Asynchronous reset mid-transaction, then a clean transaction
        send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
        send(0, 8'h22, 8'h33, 1'b0, 8'h56, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {11'd0, out_valid[0], out_last[0], carry_out[0], len_err[0], busy[0]}, 16'd0);
        chk("arst_sum", {8'd0, out_sum[0]}, 16'd0);
        chk("arst_busy_trunc_inst", {15'd0, busy[2]}, 16'd0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h10, 8'h20, 1'b1, 8'h30, 1'b1);
        idle(2); #1 chk("post_reset_carry_out", {15'd0, carry_out[0]}, 16'd0);

        idle(4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("queue_empty_%0d", k), exp_q[k].size(), 16'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
